// File: rtl/sum_bcd_converter.sv
// Sequential 7-bit binary to 3-digit BCD converter (double-dabble), start/busy/done handshake.
// Optional AUTO mode re-converts whenever the input sum differs from the last captured value.
module sum_bcd_converter #(
    parameter int IN_W   = 7,
    parameter int DIGITS = 3,
    parameter int AUTO   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int SR_W  = 4*DIGITS + IN_W;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]     last_bin_q, last_bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                done_q, done_d;

    logic [SR_W-1:0]     sr_adj;
    logic [SR_W-1:0]     sr_shift;
    logic                trigger;

    // Add-3 correction on every BCD nibble in parallel before the shift.
    assign sr_adj[IN_W-1:0] = sr_q[IN_W-1:0];
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign sr_adj[IN_W+4*i +: 4] = (sr_q[IN_W+4*i +: 4] >= 4'd5) ?
                                       sr_q[IN_W+4*i +: 4] + 4'd3 :
                                       sr_q[IN_W+4*i +: 4];
    end
    assign sr_shift = sr_adj << 1;

    assign trigger = (AUTO != 0) ? (bin != last_bin_q) : start;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        last_bin_d = last_bin_q;
        bcd_d      = bcd_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = CONV;
                    sr_d       = {{(4*DIGITS){1'b0}}, bin};
                    last_bin_d = bin;
                    cnt_d      = '0;
                end
            end
            CONV: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W-1)) begin
                    state_d = IDLE;
                    bcd_d   = sr_shift[SR_W-1 -: 4*DIGITS];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            last_bin_q <= '0;
            bcd_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            last_bin_q <= last_bin_d;
            bcd_q      <= bcd_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: doc/sum_bcd_converter.md
# sum_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the five-operand 4-bit summing adder. It takes the 7-bit sum (0..75 in normal use, 0..127 legal), converts it to three BCD digits with a shift-and-add-3 (double-dabble) state machine, and holds the digits stable for the display/LED stage. The handshake is start/busy/done. An optional auto mode re-converts whenever the incoming sum changes.

## Interface
- IN_W, 7, width of binary input; fixed at 7 for this design, and the digit count follows from it.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^IN_W - 1.
- AUTO, 0, 1 = converter self-starts whenever `bin` differs from the last value it captured; `start` is ignored.

- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of `bin`; sampled only when idle (AUTO=0).
- bin  input  IN_W  unsigned binary sum from the adder stage.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `bcd` has just been updated.
- bcd  output  4*DIGITS  result; digit 0 (ones) in bits [3:0], tens in [7:4], hundreds in [11:8].

## Operation
- States: IDLE, CONV. Internal state:
  - shift register of 4*DIGITS+IN_W bits;
  - bit counter, 0..IN_W-1;
  - `last_bin` capture register, used in AUTO mode only.
- IDLE -> CONV on a rising edge where the trigger is true:
  - AUTO=0: trigger = `start`.
  - AUTO=1: trigger = (`bin` != `last_bin`).
  - On that edge: load shift register = {zeros, `bin`}, `last_bin` <= `bin`, counter <= 0.
- CONV step, each edge:
  - Every BCD nibble >= 5 gets +3, in parallel.
  - Then the whole register shifts left by 1.
  - Counter increments.
- CONV -> IDLE on the edge that performs step IN_W (counter == IN_W-1). On that same edge:
  - `bcd` <= upper 4*DIGITS bits of the post-shift value.
  - `done` <= 1.
- `bcd` holds the previous result throughout CONV; it changes only on the completing edge or on reset.
- `bin` is sampled only on the accepting edge; changes during CONV do not affect the result.
- `start` asserted while busy is ignored and not queued. In AUTO mode a change during CONV is picked up on the first IDLE edge after completion.
- Each nibble of `bcd` is always 0..9. Inputs above 99 produce a nonzero hundreds digit.

## Timing
- Reset (async, immediate), values held while `rst` is high:
  - state = IDLE, `busy` = 0, `done` = 0, `bcd` = 0, counter = 0, shift register = 0, `last_bin` = 0.
  - In AUTO mode, after reset release a nonzero `bin` triggers a conversion on the first edge.
- Let E0 be the accepting edge:
  - `busy` = 1 from after E0 through the edge E0+IN_W.
  - `bcd`/`done` update at E0+IN_W (7 cycles).
  - `busy` = 0 and `done` = 1 during the cycle following E0+IN_W.
- `done` is high for exactly one cycle and clears on the next edge unconditionally.
- Earliest next acceptance: E0+IN_W+1. Back-to-back throughput is one result per IN_W+1 cycles.
- `busy` is a registered state decode; it has no combinational path from `start`.
- Reset mid-CONV aborts the conversion, zeroes `bcd`, and produces no `done` pulse.

## Test plan
- AUTO=0, `bin`=75, one-cycle `start` -> `busy` high 7 cycles; `bcd`=0x075 with a single `done` pulse at E0+7.
- `bin`=127 -> `bcd`=0x127. `bin`=0 -> `bcd`=0x000, `done` still pulses. `bin`=99 -> 0x099, then `bin`=100 -> 0x100.
- Start 42, then pulse `start` with `bin`=9 at E0+3 -> ignored; `bcd`=0x042, exactly one `done`. The first accepted start after `busy` falls converts 9 -> 0x009.
- Convert 60, then assert `rst` at E0+4 of a conversion of 33 -> `bcd`=0x000 and `busy`=0 immediately; no `done`. The next start converts 33 correctly.
- AUTO=1: `bin` steps 0 -> 15 -> 30 -> 30 -> converts 15 and 30 only; outputs 0x015 then 0x030, two `done` pulses.
- AUTO=1: change `bin` 20 -> 55 during CONV -> first result 0x020. The second conversion starts at the first IDLE edge; final `bcd`=0x055.
